uart_tx: RTL

//  Serial UART transmitter: accepts one byte per handshake from the word-to-byte

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and a
// helper that sizes the baud counter from the bit period.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Counter width holding 0..clks-1; never narrower than one bit.
  function automatic int baud_cnt_w(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and strobes bit_end
// on the last cycle of each bit. Shared by the transmitter and receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == LAST);

  // Wrapping on bit_end restarts the count for the next bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || bit_end) cnt_d = '0;
    else                       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per handshake, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       uart_tx_busy,
  output logic       uart_tx_done,
  output logic       txd
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept, bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign accept = (state_q == IDLE) && tx_data_valid;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (busy_q),
    .clr     (accept),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          shift_d    = tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        txd_d   = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          txd_d   = parity_q;
`else
          state_d = STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shift_q >> 1;
          txd_d     = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        txd_d   = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (stop_cnt_q == LAST_STOP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
        txd_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign txd          = txd_q;
  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;

endmodule
